// File: rtl/uart_tx_param_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and the
// clocks-per-bit computation, reused by the future parametrised receiver.
package uart_tx_param_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_t;

    // Rounded clocks per bit: (clk_hz + baud/2) / baud.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side write port and serial line status of the parametrised UART Tx.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (
        output wr_en, wr_data,
        input  full, empty, ovf, tx, busy, done
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, ovf, tx, busy, done
    );
endinterface

// File: rtl/uart_tx_param_fifo.sv
// Small synchronous write FIFO; a pop and a push in the same cycle are both
// honoured even when full, and a refused push raises a one-cycle ovf pulse.
module uart_tx_param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             ovf_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry is visible before the pop so the frame can start on that edge.
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;
    assign ovf     = ovf_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            ovf_reg <= push && !do_push;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: write FIFO feeding a start/data/parity/stop
// framer with back-to-back frames and registered line outputs.
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus
);
    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam int FAW = $clog2(FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || DIV < 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    tx_state_t            state_reg;
    logic [CW-1:0]        baud_cnt_reg;
    logic [3:0]           bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic [DATA_BITS-1:0] shreg_reg;
    logic                 par_reg;
    logic                 tx_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_ovf;
    logic [FAW:0]         fifo_count;
    logic                 pop;
    logic                 baud_last;
    logic                 done_next;
    logic                 stop_last;
    logic                 par_calc;

    uart_tx_param_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.wr_en),
        .pop     (pop),
        .wr_data (bus.wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ovf     (fifo_ovf),
        .count   (fifo_count)
    );

    assign baud_last = (baud_cnt_reg == CW'(DIV - 1));
    assign done_next = (baud_cnt_reg == CW'(DIV - 2));
    assign stop_last = (stop_cnt_reg == 1'(STOP_BITS - 1));
    assign par_calc  = (PARITY == PARITY_EVEN) ? ^fifo_rd_data : ~^fifo_rd_data;

    // A pop happens from IDLE or on the very last stop clock, so queued frames abut.
    assign pop = (fifo_count != '0) &&
                 ((state_reg == ST_IDLE) || (state_reg == ST_STOP && stop_last && baud_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shreg_reg    <= '0;
            par_reg      <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_reg       <= 1'b1;
                    busy_reg     <= 1'b0;
                    baud_cnt_reg <= '0;
                    if (pop) begin
                        shreg_reg <= fifo_rd_data;
                        par_reg   <= par_calc;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        tx_reg       <= shreg_reg[0];
                        state_reg    <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        shreg_reg    <= shreg_reg >> 1;
                        if (bit_cnt_reg == 4'(DATA_BITS - 1)) begin
                            if (PARITY != PARITY_NONE) begin
                                tx_reg    <= par_reg;
                                state_reg <= ST_PAR;
                            end else begin
                                tx_reg       <= 1'b1;
                                stop_cnt_reg <= 1'b0;
                                state_reg    <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            tx_reg      <= shreg_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                ST_PAR: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b1;
                        stop_cnt_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                ST_STOP: begin
                    // done is registered one clock early so it coincides with the final stop clock.
                    if (stop_last && done_next) begin
                        done_reg <= 1'b1;
                    end
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (!stop_last) begin
                            stop_cnt_reg <= stop_cnt_reg + 1'b1;
                        end else if (pop) begin
                            shreg_reg <= fifo_rd_data;
                            par_reg   <= par_calc;
                            tx_reg    <= 1'b0;
                            state_reg <= ST_START;
                        end else begin
                            tx_reg    <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx    = tx_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;
    assign bus.ovf   = fifo_ovf;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: several parameterisations side by side,
// every frame checked clock by clock against hand-derived bit sequences.
module tb_uart_tx_param;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] wr_en_v = '0;
    logic [8:0] wr_data = '0;
    logic [4:0] tx_v, busy_v, done_v, full_v, empty_v, ovf_v;
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8)) if_a ();
    uart_tx_param_if #(.DATA_BITS(8)) if_b ();
    uart_tx_param_if #(.DATA_BITS(8)) if_c ();
    uart_tx_param_if #(.DATA_BITS(5)) if_d ();
    uart_tx_param_if #(.DATA_BITS(8)) if_e ();

    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));
    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));
    uart_tx_param dut_e (.clk(clk), .rst(rst), .bus(if_e));

    assign if_a.wr_en = wr_en_v[0];  assign if_a.wr_data = wr_data[7:0];
    assign if_b.wr_en = wr_en_v[1];  assign if_b.wr_data = wr_data[7:0];
    assign if_c.wr_en = wr_en_v[2];  assign if_c.wr_data = wr_data[7:0];
    assign if_d.wr_en = wr_en_v[3];  assign if_d.wr_data = wr_data[4:0];
    assign if_e.wr_en = wr_en_v[4];  assign if_e.wr_data = wr_data[7:0];

    assign tx_v    = {if_e.tx,    if_d.tx,    if_c.tx,    if_b.tx,    if_a.tx};
    assign busy_v  = {if_e.busy,  if_d.busy,  if_c.busy,  if_b.busy,  if_a.busy};
    assign done_v  = {if_e.done,  if_d.done,  if_c.done,  if_b.done,  if_a.done};
    assign full_v  = {if_e.full,  if_d.full,  if_c.full,  if_b.full,  if_a.full};
    assign empty_v = {if_e.empty, if_d.empty, if_c.empty, if_b.empty, if_a.empty};
    assign ovf_v   = {if_e.ovf,   if_d.ovf,   if_c.ovf,   if_b.ovf,   if_a.ovf};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [8:0] data);
        @(negedge clk);
        wr_en_v[d] = 1'b1;
        wr_data    = data;
        @(negedge clk);
        wr_en_v[d] = 1'b0;
        wr_data    = ~data;
    endtask

    // Checks frame clocks skip+1..L; clock 1 is the first clock with tx low.
    task automatic check_frame(input int d, input string tag, input logic [8:0] data, input int nb,
                               input int has_par, input logic pbit, input int nstop, input int skip);
        logic bits [16];
        int   len;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = data[i];
        if (has_par != 0) bits[1+nb] = pbit;
        for (int s = 0; s < nstop; s++) bits[1+nb+has_par+s] = 1'b1;
        len = (1 + nb + has_par + nstop) * DIV;
        for (int k = skip + 1; k <= len; k++) begin
            @(negedge clk);
            chk($sformatf("%s tx clk %0d", tag, k), 32'(tx_v[d]), 32'(bits[(k-1)/DIV]));
            chk($sformatf("%s busy clk %0d", tag, k), 32'(busy_v[d]), 32'd1);
            chk($sformatf("%s done clk %0d", tag, k), 32'(done_v[d]), 32'(k == len));
        end
        $display("frame %s data=%h len=%0d checked", tag, data, len);
    endtask

    initial begin
        logic [7:0] burst [6];
        burst = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h99};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset tx",    32'(tx_v[0]),    32'd1);
        chk("reset busy",  32'(busy_v[0]),  32'd0);
        chk("reset done",  32'(done_v[0]),  32'd0);
        chk("reset ovf",   32'(ovf_v[0]),   32'd0);
        chk("reset full",  32'(full_v[0]),  32'd0);
        chk("reset empty", 32'(empty_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // 8N1 single frame, wr_data changed right after the push
        push(0, 9'h0A5);
        check_frame(0, "t1_8N1_A5", 9'h0A5, 8, 0, 1'b0, 1, 0);
        @(negedge clk);
        chk("t1 busy after", 32'(busy_v[0]),  32'd0);
        chk("t1 tx after",   32'(tx_v[0]),    32'd1);
        chk("t1 empty",      32'(empty_v[0]), 32'd1);

        // Even/odd parity, two stop bits; 0x07 has three ones
        push(1, 9'h007);
        check_frame(1, "t2_8E2_07", 9'h007, 8, 1, 1'b1, 2, 0);
        @(negedge clk);
        chk("t2e busy after", 32'(busy_v[1]), 32'd0);
        push(2, 9'h007);
        check_frame(2, "t2_8O2_07", 9'h007, 8, 1, 1'b0, 2, 0);

        // Three pushes on consecutive cycles -> frames back to back
        @(negedge clk); wr_en_v[0] = 1'b1; wr_data = 9'h011;
        @(negedge clk); wr_data = 9'h022;
        @(negedge clk); wr_data = 9'h033;
        @(negedge clk); wr_en_v[0] = 1'b0; wr_data = 9'h000;
        check_frame(0, "t3_f1_11", 9'h011, 8, 0, 1'b0, 1, 2);
        chk("t3 empty f1", 32'(empty_v[0]), 32'd0);
        check_frame(0, "t3_f2_22", 9'h022, 8, 0, 1'b0, 1, 0);
        chk("t3 empty f2", 32'(empty_v[0]), 32'd0);
        check_frame(0, "t3_f3_33", 9'h033, 8, 0, 1'b0, 1, 0);
        chk("t3 empty f3", 32'(empty_v[0]), 32'd1);
        @(negedge clk);
        chk("t3 busy after", 32'(busy_v[0]), 32'd0);

        // Six pushes into a depth-4 FIFO while idle: sixth one dropped
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) chk("t4 full at 3", 32'(full_v[0]), 32'd0);
            if (i == 5) begin
                chk("t4 full at 4", 32'(full_v[0]), 32'd1);
                chk("t4 ovf before", 32'(ovf_v[0]), 32'd0);
            end
            wr_en_v[0] = 1'b1;
            wr_data    = {1'b0, burst[i]};
        end
        @(negedge clk);
        chk("t4 ovf pulse", 32'(ovf_v[0]), 32'd1);
        chk("t4 full hold", 32'(full_v[0]), 32'd1);
        wr_en_v[0] = 1'b0;
        @(negedge clk);
        chk("t4 ovf end", 32'(ovf_v[0]), 32'd0);
        check_frame(0, "t4_b1", {1'b0, burst[0]}, 8, 0, 1'b0, 1, 6);
        for (int i = 1; i < 5; i++)
            check_frame(0, $sformatf("t4_b%0d", i + 1), {1'b0, burst[i]}, 8, 0, 1'b0, 1, 0);
        @(negedge clk);
        chk("t4 busy after", 32'(busy_v[0]),  32'd0);
        chk("t4 empty after", 32'(empty_v[0]), 32'd1);

        // Asynchronous reset in the middle of a frame with a byte still queued
        push(0, 9'h05A);
        push(0, 9'h0F0);
        repeat (43) @(negedge clk);
        chk("t5 tx mid frame", 32'(tx_v[0]), 32'd1);
        chk("t5 busy mid frame", 32'(busy_v[0]), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5 tx on reset",    32'(tx_v[0]),    32'd1);
        chk("t5 busy on reset",  32'(busy_v[0]),  32'd0);
        chk("t5 empty on reset", 32'(empty_v[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        push(0, 9'h03C);
        check_frame(0, "t5_after_reset_3C", 9'h03C, 8, 0, 1'b0, 1, 0);
        @(negedge clk);
        chk("t5 busy after", 32'(busy_v[0]), 32'd0);

        // Five-bit payload: upper wr_data bits must not leak into the frame
        push(3, 9'h1FF);
        check_frame(3, "t6_5N1_1F", 9'h01F, 5, 0, 1'b0, 1, 0);
        push(3, 9'h1EA);
        check_frame(3, "t6_5N1_0A", 9'h00A, 5, 0, 1'b0, 1, 0);

        // Default parameters: 50 MHz / 9600 baud -> 5208-clock start bit
        push(4, 9'h001);
        for (int k = 1; k <= 5209; k++) begin
            @(negedge clk);
            if (k == 1) chk("t6 default busy", 32'(busy_v[4]), 32'd1);
            if (k == 1 || k == 5208) chk($sformatf("t6 default start clk %0d", k), 32'(tx_v[4]), 32'd0);
            if (k == 5209) chk("t6 default bit0 clk 5209", 32'(tx_v[4]), 32'd1);
        end
        $display("frame t6_default start bit checked");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
